// File: rtl/mem_dma.sv
// Word-copy bus master on the picorv32 native memory interface: reads each
// source word, writes it to the destination, with a per-transaction timeout.
module mem_dma #(
  parameter int TIMEOUT   = 255,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [LEN_WIDTH-1:0] words_done,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic                 mem_instr,
  output logic [3:0]           mem_wstrb,
  output logic [31:0]          mem_wdata,
  output logic [31:0]          mem_addr,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_GAP, S_WR, S_WR_GAP, S_FIN} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t                r_state, w_state;
  logic [31:0]           r_src, w_src, r_dst, w_dst;
  logic [LEN_WIDTH-1:0]  r_rem, w_rem, r_words, w_words;
  logic [31:0]           r_data, w_data, r_addr, w_addr;
  logic [15:0]           r_cnt, w_cnt;
  logic                  r_valid, w_valid, r_busy, w_busy, r_done, w_done, r_error, w_error;
  logic [3:0]            r_wstrb, w_wstrb;

  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign words_done = r_words;
  assign mem_valid  = r_valid;
  assign mem_instr  = 1'b0;
  assign mem_wstrb  = r_wstrb;
  assign mem_wdata  = r_data;
  assign mem_addr   = r_addr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_words <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_wstrb <= '0;
    end else begin
      r_state <= w_state;
      r_src   <= w_src;
      r_dst   <= w_dst;
      r_rem   <= w_rem;
      r_words <= w_words;
      r_data  <= w_data;
      r_addr  <= w_addr;
      r_cnt   <= w_cnt;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_error <= w_error;
      r_wstrb <= w_wstrb;
    end
  end

  // Next-state logic; every output is the registered image of these values.
  always_comb begin
    w_state = r_state;
    w_src   = r_src;
    w_dst   = r_dst;
    w_rem   = r_rem;
    w_words = r_words;
    w_data  = r_data;
    w_addr  = r_addr;
    w_cnt   = r_cnt;
    w_valid = r_valid;
    w_error = r_error;
    w_wstrb = r_wstrb;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_src   = {src_addr[31:2], 2'b00};
          w_dst   = {dst_addr[31:2], 2'b00};
          w_rem   = word_count;
          w_words = '0;
          w_error = 1'b0;
          if (word_count == '0) begin
            w_state = S_FIN;
          end else begin
            w_state = S_RD;
            w_valid = 1'b1;
            w_addr  = {src_addr[31:2], 2'b00};
            w_wstrb = 4'h0;
            w_cnt   = '0;
          end
        end
      end
      S_RD, S_WR: begin
        if (mem_ready) begin
          w_valid = 1'b0;
          w_wstrb = 4'h0;
          if (r_state == S_RD) begin
            w_data  = mem_rdata;
            w_src   = r_src + 32'd4;
            w_state = S_RD_GAP;
          end else begin
            w_dst   = r_dst + 32'd4;
            w_words = r_words + LEN_WIDTH'(1);
            w_rem   = r_rem - LEN_WIDTH'(1);
            w_state = S_WR_GAP;
          end
        end else if (r_cnt == TO_LAST) begin
          w_valid = 1'b0;
          w_wstrb = 4'h0;
          w_error = 1'b1;
          w_state = S_FIN;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      S_RD_GAP: begin
        w_state = S_WR;
        w_valid = 1'b1;
        w_addr  = r_dst;
        w_wstrb = 4'hF;
        w_cnt   = '0;
      end
      S_WR_GAP: begin
        if (r_rem == '0) begin
          w_state = S_FIN;
        end else begin
          w_state = S_RD;
          w_valid = 1'b1;
          w_addr  = r_src;
          w_cnt   = '0;
        end
      end
      S_FIN:   w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state == S_RD) || (w_state == S_RD_GAP) ||
             (w_state == S_WR) || (w_state == S_WR_GAP);
    w_done = (w_state == S_FIN);
  end

endmodule

// File: tb/tb_mem_dma.sv
// Scoreboard bench for mem_dma: stimulus pushes expected bus completions and
// done pulses; a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_dma;
  localparam int TO = 8;

  logic        clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] word_count = '0;
  logic        busy, done, error, mem_valid, mem_ready, mem_instr;
  logic [15:0] words_done;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;

  mem_dma #(.TIMEOUT(TO), .LEN_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .word_count(word_count), .busy(busy), .done(done),
    .error(error), .words_done(words_done), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_instr(mem_instr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: ready wait_n cycles after valid rises, never if never_ready.
  logic [31:0] mem [0:1023];
  int  wait_n = 0;
  bit  never_ready = 1'b0;
  int  wcnt = 0;
  always @(posedge clk) wcnt <= mem_valid ? wcnt + 1 : 0;
  assign mem_ready = mem_valid && !never_ready && (wcnt >= wait_n);
  assign mem_rdata = mem_valid ? mem[mem_addr[11:2]] : 32'h0;
  always @(posedge clk)
    if (mem_valid && mem_ready && mem_wstrb == 4'hF) mem[mem_addr[11:2]] <= mem_wdata;

  typedef struct { logic [31:0] addr; logic we; logic [31:0] data; } bus_t;
  typedef struct { int cyc; int words; logic err; } done_t;
  bus_t  bq[$];
  done_t dq[$];

  int n_cmp = 0, n_bad = 0;
  int vcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (mem_valid) begin
        vcnt++;
        chk("addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
      end
      if (mem_valid && mem_ready) begin
        if (bq.size() == 0) fail_now("unexpected_bus_xfer");
        else begin
          bus_t e;
          e = bq.pop_front();
          chk("bus_addr", mem_addr, e.addr);
          chk("bus_wstrb", {28'b0, mem_wstrb}, e.we ? 32'hF : 32'h0);
          if (e.we) chk("bus_wdata", mem_wdata, e.data);
        end
      end
      if (done) begin
        if (dq.size() == 0) fail_now("unexpected_done");
        else begin
          done_t d;
          d = dq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(d.cyc));
          chk("words_done", {16'b0, words_done}, 32'(d.words));
          chk("error", {31'b0, error}, {31'b0, d.err});
        end
      end
    end
  end

  task automatic push_rw(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd);
    bus_t e;
    e.addr = ra; e.we = 1'b0; e.data = 32'h0; bq.push_back(e);
    e.addr = wa; e.we = 1'b1; e.data = wd;    bq.push_back(e);
  endtask

  // Issues start in cycle 0; returns at the negedge of cycle 1.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input int rel, input int words, input logic err);
    done_t e;
    @(negedge clk);
    src_addr = s; dst_addr = d; word_count = n; start = 1'b1;
    e.cyc = cyc + rel; e.words = words; e.err = err;
    dq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && dq.size() != 0; i++) @(negedge clk);
    if (dq.size() != 0) begin
      fail_now("done_never_arrived");
      dq.delete();
      bq.delete();
    end
    @(negedge clk);
  endtask

  task automatic scen_copy4();
    logic [31:0] vals [4];
    vals[0] = 32'h11111111; vals[1] = 32'h22222222;
    vals[2] = 32'h33333333; vals[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) begin
      mem[16 * 4 + i] = vals[i];
      mem[32 * 4 + i] = 32'h0;
      push_rw(32'h100 + 32'(4 * i), 32'h200 + 32'(4 * i), vals[i]);
    end
    vcnt = 0;
    run_copy(32'h100, 32'h200, 16'd4, 17, 4, 1'b0);
    chk("busy_cycle1", {31'b0, busy}, 32'h1);
    chk("valid_cycle1", {31'b0, mem_valid}, 32'h1);
    wait_done(40);
    chk("copy4_valid_cycles", 32'(vcnt), 32'd8);
    for (int i = 0; i < 4; i++) chk("copy4_dst", mem[32 * 4 + i], vals[i]);
    chk("copy4_busy_after", {31'b0, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, mem_valid}, 32'h0);
    chk("rst_wstrb", {28'b0, mem_wstrb}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_flags", {28'b0, busy, done, error, mem_instr}, 32'h0);
    chk("rst_words", {16'b0, words_done}, 32'h0);
    resetn = 1'b1;

    // 4-word zero-wait copy
    scen_copy4();

    // Zero-length start
    vcnt = 0;
    run_copy(32'h500, 32'h600, 16'd0, 1, 0, 1'b0);
    wait_done(10);
    chk("zero_len_valid_cycles", 32'(vcnt), 32'd0);

    // Timeout: responder never ready
    never_ready = 1'b1;
    vcnt = 0;
    run_copy(32'h104, 32'h204, 16'd3, 1 + TO, 0, 1'b1);
    chk("timeout_addr", mem_addr, 32'h104);
    wait_done(30);
    chk("timeout_valid_cycles", 32'(vcnt), 32'(TO));
    chk("timeout_error_held", {31'b0, error}, 32'h1);
    never_ready = 1'b0;
    mem[16 * 4] = 32'h11111111;
    push_rw(32'h100, 32'h280, 32'h11111111);
    run_copy(32'h100, 32'h280, 16'd1, 5, 1, 1'b0);
    chk("error_cleared", {31'b0, error}, 32'h0);
    wait_done(20);

    // Wait states: ready 3 cycles after valid
    wait_n = 3;
    push_rw(32'h108, 32'h2C0, 32'h33333333);
    push_rw(32'h10C, 32'h2C4, 32'h44444444);
    run_copy(32'h108, 32'h2C0, 16'd2, 21, 2, 1'b0);
    wait_done(40);
    wait_n = 0;
    chk("wait_dst0", mem[32'h2C0 >> 2], 32'h33333333);
    chk("wait_dst1", mem[32'h2C4 >> 2], 32'h44444444);

    // start during a copy is ignored
    push_rw(32'h100, 32'h2E0, 32'h11111111);
    push_rw(32'h104, 32'h2E4, 32'h22222222);
    run_copy(32'h100, 32'h2E0, 16'd2, 9, 2, 1'b0);
    @(negedge clk);
    src_addr = 32'h400; dst_addr = 32'h440; word_count = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(30);
    repeat (10) @(negedge clk);

    // Address wrap, low address bits ignored
    mem[1023] = 32'hDEADBEEF;
    mem[0]    = 32'hCAFEF00D;
    push_rw(32'hFFFFFFFC, 32'h300, 32'hDEADBEEF);
    push_rw(32'h00000000, 32'h304, 32'hCAFEF00D);
    run_copy(32'hFFFFFFFE, 32'h302, 16'd2, 9, 2, 1'b0);
    wait_done(30);
    chk("wrap_dst1", mem[32'h304 >> 2], 32'hCAFEF00D);

    // Reset during WR
    push_rw(32'h100, 32'h200, 32'h11111111);
    push_rw(32'h104, 32'h204, 32'h22222222);
    run_copy(32'h100, 32'h200, 16'd2, 9, 2, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, mem_valid}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_wstrb", {28'b0, mem_wstrb}, 32'h0);
    bq.delete();
    dq.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    scen_copy4();

    chk("bus_queue_empty", 32'(bq.size()), 32'h0);
    chk("done_queue_empty", 32'(dq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
